// File: rtl/burst_splitter_pkg.sv
// Shared DMA types and constants for the burst splitter: transfer command record,
// status encodings, beat size and the splitter FSM state type.
package DmaPkg;

    typedef struct packed {
        logic [31:0] Address;
        logic [31:0] NumBytes;
    } TransCmd_t;

    localparam logic [1:0] STAT_OKAY   = 2'b00;
    localparam logic [1:0] STAT_SLVERR = 2'b10;
    localparam logic [1:0] STAT_DECERR = 2'b11;

    localparam int unsigned BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_DRAIN,
        ST_RESP
    } split_state_e;

endpackage

// File: rtl/burst_splitter_if.sv
// Transfer command/status channels (DMA side) and sub-command/status channels
// (engine side) of one burst splitter. slave = splitter view, master = environment view.
interface burst_splitter_if;

    logic        TransCmd_Valid;
    logic        TransCmd_Ready;
    logic [31:0] TransCmd_Address;
    logic [31:0] TransCmd_NumBytes;
    logic        TransStat_Valid;
    logic        TransStat_Ready;
    logic [1:0]  TransStat_Data;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [31:0] Cmd_Address;
    logic [31:0] Cmd_NumBytes;
    logic        Stat_Valid;
    logic        Stat_Ready;
    logic [1:0]  Stat_Data;

    modport slave (
        input  TransCmd_Valid, TransCmd_Address, TransCmd_NumBytes, TransStat_Ready,
               Cmd_Ready, Stat_Valid, Stat_Data,
        output TransCmd_Ready, TransStat_Valid, TransStat_Data,
               Cmd_Valid, Cmd_Address, Cmd_NumBytes, Stat_Ready
    );

    modport master (
        output TransCmd_Valid, TransCmd_Address, TransCmd_NumBytes, TransStat_Ready,
               Cmd_Ready, Stat_Valid, Stat_Data,
        input  TransCmd_Ready, TransStat_Valid, TransStat_Data,
               Cmd_Valid, Cmd_Address, Cmd_NumBytes, Stat_Ready
    );

endinterface

// File: rtl/burst_splitter_calc.sv
// Combinational chunk size: the largest sub-command starting at cur_addr that
// fits the remaining bytes, the burst length limit and the next address boundary.
module burst_calc
    import DmaPkg::*;
#(
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter int unsigned BOUNDARY        = 4096
) (
    input  logic [31:0] cur_addr,
    input  logic [31:0] remaining,
    output logic [31:0] chunk
);

    localparam logic [31:0] MAX_BYTES = 32'(MAX_BURST_BEATS * BEAT_BYTES);
    localparam logic [31:0] BND       = 32'(BOUNDARY);

    logic [31:0] to_boundary;
    logic [31:0] limit;

    always_comb begin
        to_boundary = BND - (cur_addr & (BND - 32'd1));
        limit       = (to_boundary < MAX_BYTES) ? to_boundary : MAX_BYTES;
        chunk       = (remaining < limit) ? remaining : limit;
    end

endmodule

// File: rtl/burst_splitter.sv
// Splits one DMA transfer into boundary-safe bursts and merges their statuses.
// Optional BURST_SPLITTER_PERF_EN adds the BurstCount sub-command counter output.
module burst_splitter
    import DmaPkg::*;
#(
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BOUNDARY        = 4096
) (
    input  logic              ACLK,
    input  logic              ARESET,
    burst_splitter_if.slave   bus
`ifdef BURST_SPLITTER_PERF_EN
    ,
    output logic [15:0]       BurstCount
`endif
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    split_state_e state_q, state_d;
    logic [31:0]  cur_addr_q, cur_addr_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [31:0]  cmd_addr_q, cmd_addr_d;
    logic [31:0]  cmd_nbytes_q, cmd_nbytes_d;
    logic [1:0]   merged_q, merged_d;
    logic [1:0]   tstat_data_q, tstat_data_d;
    logic [3:0]   outst_q, outst_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         tcmd_ready_q, tcmd_ready_d;
    logic         tstat_valid_q, tstat_valid_d;

    TransCmd_t    tcmd;
    logic [31:0]  calc_addr, calc_rem, chunk;
    logic         stat_ready, tcmd_hs, cmd_hs, stat_hs, tstat_hs;

    always_comb begin
        tcmd.Address  = bus.TransCmd_Address;
        tcmd.NumBytes = bus.TransCmd_NumBytes;
        stat_ready    = (state_q == ST_SPLIT) || (state_q == ST_DRAIN);
        tcmd_hs       = bus.TransCmd_Valid & tcmd_ready_q;
        cmd_hs        = cmd_valid_q & bus.Cmd_Ready;
        stat_hs       = bus.Stat_Valid & stat_ready;
        tstat_hs      = tstat_valid_q & bus.TransStat_Ready;
        // In IDLE the first chunk is sized straight from the incoming command.
        calc_addr     = (state_q == ST_IDLE) ? tcmd.Address  : cur_addr_q;
        calc_rem      = (state_q == ST_IDLE) ? tcmd.NumBytes : remaining_q;
    end

    burst_calc #(
        .MAX_BURST_BEATS(MAX_BURST_BEATS),
        .BOUNDARY       (BOUNDARY)
    ) u_calc (
        .cur_addr (calc_addr),
        .remaining(calc_rem),
        .chunk    (chunk)
    );

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_nbytes_d  = cmd_nbytes_q;
        tstat_data_d  = tstat_data_q;
        cmd_valid_d   = cmd_valid_q;
        tcmd_ready_d  = tcmd_ready_q;
        tstat_valid_d = tstat_valid_q;
        outst_d       = outst_q + {3'b000, cmd_hs} - {3'b000, stat_hs};
        merged_d      = merged_q;
        if (stat_hs && (merged_q == STAT_OKAY)) begin
            merged_d = bus.Stat_Data;
        end

        case (state_q)
            ST_IDLE: begin
                tcmd_ready_d = 1'b1;
                if (tcmd_hs) begin
                    tcmd_ready_d = 1'b0;
                    cur_addr_d   = tcmd.Address;
                    remaining_d  = tcmd.NumBytes;
                    merged_d     = STAT_OKAY;
                    if (tcmd.NumBytes == 32'd0) begin
                        state_d       = ST_RESP;
                        merged_d      = STAT_SLVERR;
                        tstat_valid_d = 1'b1;
                        tstat_data_d  = STAT_SLVERR;
                    end else begin
                        state_d      = ST_SPLIT;
                        cmd_valid_d  = 1'b1;
                        cmd_addr_d   = tcmd.Address;
                        cmd_nbytes_d = chunk;
                    end
                end
            end
            ST_SPLIT: begin
                if (cmd_hs) begin
                    cmd_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + cmd_nbytes_q;
                    remaining_d = remaining_q - cmd_nbytes_q;
                    if (remaining_q == cmd_nbytes_q) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!cmd_valid_q && (outst_q < MAX_OUT)) begin
                    cmd_valid_d  = 1'b1;
                    cmd_addr_d   = cur_addr_q;
                    cmd_nbytes_d = chunk;
                end
            end
            ST_DRAIN: begin
                if (outst_q == 4'd0) begin
                    state_d       = ST_RESP;
                    tstat_valid_d = 1'b1;
                    tstat_data_d  = merged_q;
                end
            end
            ST_RESP: begin
                if (tstat_hs) begin
                    state_d       = ST_IDLE;
                    tstat_valid_d = 1'b0;
                    tcmd_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            cmd_addr_q    <= '0;
            cmd_nbytes_q  <= '0;
            merged_q      <= STAT_OKAY;
            tstat_data_q  <= STAT_OKAY;
            outst_q       <= '0;
            cmd_valid_q   <= 1'b0;
            tcmd_ready_q  <= 1'b0;
            tstat_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_nbytes_q  <= cmd_nbytes_d;
            merged_q      <= merged_d;
            tstat_data_q  <= tstat_data_d;
            outst_q       <= outst_d;
            cmd_valid_q   <= cmd_valid_d;
            tcmd_ready_q  <= tcmd_ready_d;
            tstat_valid_q <= tstat_valid_d;
        end
    end

    assign bus.TransCmd_Ready  = tcmd_ready_q;
    assign bus.TransStat_Valid = tstat_valid_q;
    assign bus.TransStat_Data  = tstat_data_q;
    assign bus.Cmd_Valid       = cmd_valid_q;
    assign bus.Cmd_Address     = cmd_addr_q;
    assign bus.Cmd_NumBytes    = cmd_nbytes_q;
    assign bus.Stat_Ready      = stat_ready;

`ifdef BURST_SPLITTER_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] burst_count_q, burst_count_d;

    always_comb begin
        burst_count_d = burst_count_q;
        if (tcmd_hs) begin
            burst_count_d = 16'd0;
        end else if (cmd_hs) begin
            burst_count_d = sat_inc16(burst_count_q);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            burst_count_q <= '0;
        end else begin
            burst_count_q <= burst_count_d;
        end
    end

    assign BurstCount = burst_count_q;
`endif

endmodule
